// File: rtl/relu_maxpool_pkg.sv
// Shared types and sizing helpers for the pooling stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cnn_pkg;
    localparam int DATA_W = 13;

    typedef logic signed [DATA_W-1:0] data_t;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_DONE = 1'b1
    } state_t;

    function automatic int calc_p(input int n, input int m);
        return n - m + 1;
    endfunction

    function automatic int calc_q(input int p, input int k);
        return p / k;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/pool_row_buf.sv
// Per-output-column running max for the current window-row band.
// Latency: dout is combinational from idx/din; the entry updates on the next edge.
// Backpressure: none; a write happens on every cycle wr is high.
module pool_row_buf
    import cnn_pkg::*;
#(
    parameter int Q  = 2,
    parameter int IW = idx_w(Q)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic          init,
    input  logic [IW-1:0] idx,
    input  data_t         din,
    output data_t         dout
);
    data_t mem [Q];

    // First sample of a window overwrites, so no sentinel minimum value is needed.
    always_comb begin
        dout = (init || (din > mem[idx])) ? din : mem[idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Q; i++) mem[i] <= '0;
        end else if (wr) begin
            mem[idx] <= dout;
        end
    end
endmodule

// File: rtl/relu_maxpool.sv
// Non-overlapping KxK max pooling on a raster conv stream; RELU_EN clamps outputs to >= 0.
// Latency: out_en exactly 1 cycle after the sample that completes a window.
// Backpressure: none; accepts a sample on every a_en, ignores input once done.
module relu_maxpool
    import cnn_pkg::*;
#(
    parameter int N = 6,
    parameter int M = 3,
    parameter int K = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] a,
    input  logic                     a_en,
    input  logic                     a_done,
    output logic signed [DATA_W-1:0] out,
    output logic                     out_en,
    output logic                     done
);
    localparam int P    = calc_p(N, M);
    localparam int Q    = calc_q(P, K);
    localparam int QK   = Q * K;
    localparam int QQ   = Q * Q;
    localparam int PW   = idx_w(P);
    localparam int KW   = idx_w(K);
    localparam int OW   = idx_w(Q);
    localparam int CNTW = $clog2(QQ + 1);

    logic [PW-1:0]   col, row;
    logic [KW-1:0]   wc, wr;
    logic [OW-1:0]   oc;
    logic [CNTW-1:0] out_cnt;
    logic            done_seen;
    state_t          state;

    logic  accept, in_win, win_first, win_last;
    data_t pooled, res;

    always_comb begin
        accept    = (state == S_RUN) && a_en;
        in_win    = (32'(col) < QK) && (32'(row) < QK);
        win_first = in_win && (wc == '0) && (wr == '0);
        win_last  = in_win && (wc == KW'(K - 1)) && (wr == KW'(K - 1));
`ifdef RELU_EN
        res = pooled[DATA_W-1] ? '0 : pooled;
`else
        res = pooled;
`endif
    end

    pool_row_buf #(.Q(Q), .IW(OW)) u_row_buf (
        .clk  (clk),
        .rst  (rst),
        .wr   (accept && in_win),
        .init (win_first),
        .idx  (oc),
        .din  (a),
        .dout (pooled)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            wc        <= '0;
            wr        <= '0;
            oc        <= '0;
            out_cnt   <= '0;
            done_seen <= 1'b0;
            state     <= S_RUN;
            out       <= '0;
            out_en    <= 1'b0;
            done      <= 1'b0;
        end else begin
            out_en <= 1'b0;
            if (a_done) done_seen <= 1'b1;

            if (state == S_RUN) begin
                if (accept) begin
                    // wr steps at each input row end so columns beyond QK still close the row.
                    if (col == PW'(P - 1)) begin
                        col <= '0;
                        row <= (row == PW'(P - 1)) ? '0 : row + 1'b1;
                        if (32'(row) < QK) wr <= (wr == KW'(K - 1)) ? '0 : wr + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end

                    if (in_win) begin
                        if (wc == KW'(K - 1)) begin
                            wc <= '0;
                            oc <= (oc == OW'(Q - 1)) ? '0 : oc + 1'b1;
                        end else begin
                            wc <= wc + 1'b1;
                        end
                    end

                    if (win_last) begin
                        out    <= res;
                        out_en <= 1'b1;
                        if (out_cnt != CNTW'(QQ)) out_cnt <= out_cnt + 1'b1;
                    end
                end

                if ((out_cnt == CNTW'(QQ)) && done_seen) begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end
            end else begin
                done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_relu_maxpool.sv
// Directed bench for relu_maxpool: N=6/M=3/K=2 and N=7/M=3/K=2 instances share one input stream.
module tb_relu_maxpool;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [12:0] a = '0;
    logic               a_en = 1'b0;
    logic               a_done = 1'b0;
    logic signed [12:0] out6, out7;
    logic               out_en6, out_en7, done6, done7;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses6  = 0;

    always #5 clk = ~clk;

    relu_maxpool #(.N(6), .M(3), .K(2)) dut6 (
        .clk(clk), .rst(rst), .a(a), .a_en(a_en), .a_done(a_done),
        .out(out6), .out_en(out_en6), .done(done6)
    );

    relu_maxpool #(.N(7), .M(3), .K(2)) dut7 (
        .clk(clk), .rst(rst), .a(a), .a_en(a_en), .a_done(a_done),
        .out(out7), .out_en(out_en7), .done(done7)
    );

    always @(posedge clk) begin
        #1;
        if (out_en6) pulses6++;
    end

    function automatic logic signed [12:0] relu_exp(input logic signed [12:0] v);
`ifdef RELU_EN
        return (v < 0) ? 13'sd0 : v;
`else
        return v;
`endif
    endfunction

    task automatic do_reset();
        rst = 1'b1; a_en = 1'b0; a_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives one sample at a negedge and returns both DUTs' outputs one cycle later.
    task automatic send(input logic signed [12:0] v, input int gap,
                        output logic e6, output logic signed [12:0] o6,
                        output logic e7, output logic signed [12:0] o7);
        a = v; a_en = 1'b1;
        @(negedge clk);
        a_en = 1'b0;
        e6 = out_en6; o6 = out6; e7 = out_en7; o7 = out7;
        repeat (gap) @(negedge clk);
    endtask

    task automatic pulse_a_done();
        a_done = 1'b1;
        @(negedge clk);
        a_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (out6 !== 13'sd0)   begin n_fail++; $display("FAIL reset out6 got %0d want 0", out6); end
        n_checks++; if (out_en6 !== 1'b0)  begin n_fail++; $display("FAIL reset out_en6 got %b want 0", out_en6); end
        n_checks++; if (done6 !== 1'b0)    begin n_fail++; $display("FAIL reset done6 got %b want 0", done6); end
        n_checks++; if (out7 !== 13'sd0)   begin n_fail++; $display("FAIL reset out7 got %0d want 0", out7); end
        n_checks++; if (out_en7 !== 1'b0)  begin n_fail++; $display("FAIL reset out_en7 got %b want 0", out_en7); end
        n_checks++; if (done7 !== 1'b0)    begin n_fail++; $display("FAIL reset done7 got %b want 0", done7); end
    endtask

    task automatic test_basic();
        int exp16 [16] = '{0,0,0,0,0,6,0,8,0,0,0,0,0,14,0,16};
        logic e6, e7; logic signed [12:0] o6, o7;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send(13'(i + 1), 2, e6, o6, e7, o7);
            n_checks++;
            if (e6 !== (exp16[i] != 0)) begin n_fail++; $display("FAIL basic out_en sample %0d got %b want %b", i + 1, e6, exp16[i] != 0); end
            if (exp16[i] != 0) begin
                n_checks++;
                if (o6 !== 13'(exp16[i])) begin n_fail++; $display("FAIL basic out sample %0d got %0d want %0d", i + 1, o6, exp16[i]); end
            end
        end
        n_checks++; if (done6 !== 1'b0) begin n_fail++; $display("FAIL basic done before a_done got %b want 0", done6); end
        pulse_a_done();
        n_checks++; if (done6 !== 1'b1) begin n_fail++; $display("FAIL basic done after a_done got %b want 1", done6); end
    endtask

    task automatic test_back_to_back();
        logic e6, e7; logic signed [12:0] o6, o7;
        int n_out = 0;
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            send(-13'sd5, 0, e6, o6, e7, o7);
            n_checks++;
            if (e6 !== (i == 6 || i == 8 || i == 14 || i == 16)) begin n_fail++; $display("FAIL b2b out_en sample %0d got %b", i, e6); end
            if (e6 === 1'b1) begin
                n_out++;
                n_checks++;
                if (o6 !== relu_exp(-13'sd5)) begin n_fail++; $display("FAIL b2b out sample %0d got %0d want %0d", i, o6, relu_exp(-13'sd5)); end
            end
        end
        n_checks++; if (n_out != 4) begin n_fail++; $display("FAIL b2b output count got %0d want 4", n_out); end
    endtask

    task automatic test_floor();
        logic e6, e7; logic signed [12:0] o6, o7;
        do_reset();
        for (int i = 1; i <= 25; i++) begin
            int expv;
            expv = (i == 7 || i == 9 || i == 17 || i == 19) ? i : 0;
            send(13'(i), 1, e6, o6, e7, o7);
            n_checks++;
            if (e7 !== (expv != 0)) begin n_fail++; $display("FAIL floor out_en sample %0d got %b want %b", i, e7, expv != 0); end
            if (expv != 0) begin
                n_checks++;
                if (o7 !== 13'(expv)) begin n_fail++; $display("FAIL floor out sample %0d got %0d want %0d", i, o7, expv); end
            end
        end
        pulse_a_done();
        n_checks++; if (done7 !== 1'b1) begin n_fail++; $display("FAIL floor done got %b want 1", done7); end
    endtask

    task automatic test_mixed_sign();
        logic signed [12:0] vals [16] = '{-13'sd4096, -13'sd1, 13'sd100, -13'sd7,
                                          -13'sd3,    -13'sd2, -13'sd8,  -13'sd9,
                                          13'sd0,     -13'sd4096, 13'sd5, 13'sd4,
                                          -13'sd1,    -13'sd1, 13'sd3,  13'sd6};
        logic signed [12:0] raw [4] = '{-13'sd1, 13'sd100, 13'sd0, 13'sd6};
        logic e6, e7; logic signed [12:0] o6, o7;
        int k = 0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send(vals[i], 0, e6, o6, e7, o7);
            if (e6 === 1'b1 && k < 4) begin
                n_checks++;
                if (o6 !== relu_exp(raw[k])) begin n_fail++; $display("FAIL mixed out window %0d got %0d want %0d", k, o6, relu_exp(raw[k])); end
                k++;
            end
        end
        n_checks++; if (k != 4) begin n_fail++; $display("FAIL mixed output count got %0d want 4", k); end
    endtask

    task automatic test_mid_reset();
        int exp16 [16] = '{0,0,0,0,0,6,0,8,0,0,0,0,0,14,0,16};
        logic e6, e7; logic signed [12:0] o6, o7;
        int p0;
        do_reset();
        for (int i = 0; i < 10; i++) send(13'(i + 1), 0, e6, o6, e7, o7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (out_en6 !== 1'b0) begin n_fail++; $display("FAIL midrst out_en got %b want 0", out_en6); end
        n_checks++; if (out6 !== 13'sd0)  begin n_fail++; $display("FAIL midrst out got %0d want 0", out6); end
        p0 = pulses6;
        for (int i = 0; i < 16; i++) begin
            send(13'(i + 1), 1, e6, o6, e7, o7);
            n_checks++;
            if (e6 !== (exp16[i] != 0)) begin n_fail++; $display("FAIL midrst out_en sample %0d got %b want %b", i + 1, e6, exp16[i] != 0); end
            if (exp16[i] != 0) begin
                n_checks++;
                if (o6 !== 13'(exp16[i])) begin n_fail++; $display("FAIL midrst out sample %0d got %0d want %0d", i + 1, o6, exp16[i]); end
            end
        end
        n_checks++; if (pulses6 - p0 != 4) begin n_fail++; $display("FAIL midrst pulse count got %0d want 4", pulses6 - p0); end
    endtask

    task automatic test_early_done();
        logic e6, e7; logic signed [12:0] o6, o7;
        int p0;
        do_reset();
        for (int i = 1; i <= 12; i++) send(13'(i), 0, e6, o6, e7, o7);
        pulse_a_done();
        n_checks++; if (done6 !== 1'b0) begin n_fail++; $display("FAIL early done after a_done got %b want 0", done6); end
        for (int i = 13; i <= 16; i++) begin
            send(13'(i), 0, e6, o6, e7, o7);
            if (i == 14 || i == 16) begin
                n_checks++;
                if (e6 !== 1'b1 || o6 !== 13'(i)) begin n_fail++; $display("FAIL early out sample %0d got en=%b out=%0d want en=1 out=%0d", i, e6, o6, i); end
            end
        end
        n_checks++; if (done6 !== 1'b0) begin n_fail++; $display("FAIL early done with 4th output got %b want 0", done6); end
        @(negedge clk);
        n_checks++; if (done6 !== 1'b1) begin n_fail++; $display("FAIL early done after 4th output got %b want 1", done6); end
        p0 = pulses6;
        for (int i = 0; i < 6; i++) begin
            send(13'sd50, 0, e6, o6, e7, o7);
            n_checks++;
            if (e6 !== 1'b0) begin n_fail++; $display("FAIL early post-done out_en pulse %0d got %b want 0", i, e6); end
        end
        @(negedge clk);
        n_checks++; if (pulses6 != p0) begin n_fail++; $display("FAIL early post-done pulse count got %0d want 0", pulses6 - p0); end
        n_checks++; if (done6 !== 1'b1) begin n_fail++; $display("FAIL early done sticky got %b want 1", done6); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_floor();
        test_mixed_sign();
        test_mid_reset();
        test_early_done();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
